// File: rtl/axi_bresp_gen.sv
// Slave-side AXI write-response generator: pairs completed write bursts with their
// AW ID/USER in arrival order and issues one B response per burst.
module axi_bresp_gen #(
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 2,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [ID_WIDTH-1:0]        in_sawid,
    input  logic [USER_WIDTH-1:0]      in_sawuser,
    input  logic                       in_sawvalid,
    output logic                       out_sawready,
    input  logic                       in_swlast,
    input  logic                       in_swerr,
    input  logic                       in_swvalid,
    output logic                       out_swready,
    output logic [ID_WIDTH-1:0]        out_sbid,
    output logic [1:0]                 out_sbresp,
    output logic [USER_WIDTH-1:0]      out_sbuser,
    output logic                       out_sbvalid,
    input  logic                       in_sbready,
    output logic [$clog2(DEPTH):0]     out_pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW_W  = ID_WIDTH + USER_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AW FIFO storage and control
    logic [AW_W-1:0]       aw_mem_q [DEPTH];
    logic [PTR_W-1:0]      aw_wr_ptr_q, aw_wr_ptr_d;
    logic [PTR_W-1:0]      aw_rd_ptr_q, aw_rd_ptr_d;
    logic [CNT_W-1:0]      aw_cnt_q, aw_cnt_d;

    // Completion FIFO: one error flag per finished burst
    logic [DEPTH-1:0]      cmp_mem_q;
    logic [PTR_W-1:0]      cmp_wr_ptr_q, cmp_wr_ptr_d;
    logic [PTR_W-1:0]      cmp_rd_ptr_q, cmp_rd_ptr_d;
    logic [CNT_W-1:0]      cmp_cnt_q, cmp_cnt_d;

    logic                  err_acc_q, err_acc_d;

    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [USER_WIDTH-1:0] buser_q, buser_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  bvalid_q, bvalid_d;

    logic                  aw_push;
    logic                  w_accept;
    logic                  cmp_push;
    logic                  cmp_flag;
    logic                  issue;
    logic [AW_W-1:0]       aw_head;
    logic                  cmp_head;

    // Ready is forced low during reset, not just derived from the cleared count.
    assign out_sawready = reset_ & (aw_cnt_q != FULL_CNT);
    assign out_swready  = reset_ & (cmp_cnt_q != FULL_CNT);

    assign aw_push  = in_sawvalid & out_sawready;
    assign w_accept = in_swvalid & out_swready;
    assign cmp_push = w_accept & in_swlast;
    assign cmp_flag = err_acc_q | in_swerr;

    assign aw_head  = aw_mem_q[aw_rd_ptr_q];
    assign cmp_head = cmp_mem_q[cmp_rd_ptr_q];

    assign issue = (aw_cnt_q != '0) & (cmp_cnt_q != '0) & (~bvalid_q | in_sbready);

    always_comb begin
        aw_wr_ptr_d = aw_wr_ptr_q;
        aw_rd_ptr_d = aw_rd_ptr_q;
        aw_cnt_d    = aw_cnt_q;
        if (aw_push) begin
            aw_wr_ptr_d = aw_wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            aw_rd_ptr_d = aw_rd_ptr_q + PTR_W'(1);
        end
        case ({aw_push, issue})
            2'b10:   aw_cnt_d = aw_cnt_q + CNT_W'(1);
            2'b01:   aw_cnt_d = aw_cnt_q - CNT_W'(1);
            default: aw_cnt_d = aw_cnt_q;
        endcase
    end

    always_comb begin
        cmp_wr_ptr_d = cmp_wr_ptr_q;
        cmp_rd_ptr_d = cmp_rd_ptr_q;
        cmp_cnt_d    = cmp_cnt_q;
        if (cmp_push) begin
            cmp_wr_ptr_d = cmp_wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            cmp_rd_ptr_d = cmp_rd_ptr_q + PTR_W'(1);
        end
        case ({cmp_push, issue})
            2'b10:   cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
            2'b01:   cmp_cnt_d = cmp_cnt_q - CNT_W'(1);
            default: cmp_cnt_d = cmp_cnt_q;
        endcase
    end

    // Error accumulates across non-last beats and restarts with each new burst.
    always_comb begin
        err_acc_d = err_acc_q;
        if (w_accept) begin
            err_acc_d = in_swlast ? 1'b0 : cmp_flag;
        end
    end

    always_comb begin
        bid_d    = bid_q;
        buser_d  = buser_q;
        bresp_d  = bresp_q;
        bvalid_d = bvalid_q;
        if (issue) begin
            bid_d    = aw_head[AW_W-1:USER_WIDTH];
            buser_d  = aw_head[USER_WIDTH-1:0];
            bresp_d  = cmp_head ? RESP_SLVERR : RESP_OKAY;
            bvalid_d = 1'b1;
        end else if (bvalid_q && in_sbready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                aw_mem_q[i] <= '0;
            end
            aw_wr_ptr_q <= '0;
            aw_rd_ptr_q <= '0;
            aw_cnt_q    <= '0;
        end else begin
            if (aw_push) begin
                aw_mem_q[aw_wr_ptr_q] <= {in_sawid, in_sawuser};
            end
            aw_wr_ptr_q <= aw_wr_ptr_d;
            aw_rd_ptr_q <= aw_rd_ptr_d;
            aw_cnt_q    <= aw_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cmp_mem_q    <= '0;
            cmp_wr_ptr_q <= '0;
            cmp_rd_ptr_q <= '0;
            cmp_cnt_q    <= '0;
            err_acc_q    <= 1'b0;
        end else begin
            if (cmp_push) begin
                cmp_mem_q[cmp_wr_ptr_q] <= cmp_flag;
            end
            cmp_wr_ptr_q <= cmp_wr_ptr_d;
            cmp_rd_ptr_q <= cmp_rd_ptr_d;
            cmp_cnt_q    <= cmp_cnt_d;
            err_acc_q    <= err_acc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bid_q    <= '0;
            buser_q  <= '0;
            bresp_q  <= '0;
            bvalid_q <= 1'b0;
        end else begin
            bid_q    <= bid_d;
            buser_q  <= buser_d;
            bresp_q  <= bresp_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign out_sbid    = bid_q;
    assign out_sbuser  = buser_q;
    assign out_sbresp  = bresp_q;
    assign out_sbvalid = bvalid_q;
    // Each AW leaves the FIFO exactly when its B is issued, so the count is the pending total.
    assign out_pending = aw_cnt_q;

endmodule

// File: tb/tb_axi_bresp_gen.sv
// Scoreboard bench for axi_bresp_gen: a negedge monitor feeds a queue-based reference
// model from observed handshakes and checks every B against the expected pairing.
module tb_axi_bresp_gen;

    logic        clk;
    logic        reset_;
    logic [7:0]  in_sawid;
    logic [1:0]  in_sawuser;
    logic        in_sawvalid;
    logic        out_sawready;
    logic        in_swlast;
    logic        in_swerr;
    logic        in_swvalid;
    logic        out_swready;
    logic [7:0]  out_sbid;
    logic [1:0]  out_sbresp;
    logic [1:0]  out_sbuser;
    logic        out_sbvalid;
    logic        in_sbready;
    logic [3:0]  out_pending;

    axi_bresp_gen #(
        .ID_WIDTH   (8),
        .USER_WIDTH (2),
        .DEPTH      (8)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .in_sawid     (in_sawid),
        .in_sawuser   (in_sawuser),
        .in_sawvalid  (in_sawvalid),
        .out_sawready (out_sawready),
        .in_swlast    (in_swlast),
        .in_swerr     (in_swerr),
        .in_swvalid   (in_swvalid),
        .out_swready  (out_swready),
        .out_sbid     (out_sbid),
        .out_sbresp   (out_sbresp),
        .out_sbuser   (out_sbuser),
        .out_sbvalid  (out_sbvalid),
        .in_sbready   (in_sbready),
        .out_pending  (out_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nb    = 0;

    // Reference model state: accepted AWs, finished bursts, expected B payloads {id,resp,user}
    logic [9:0]  model_aw  [$];
    logic        model_cmp [$];
    logic [11:0] exp_q     [$];
    logic        model_acc;
    logic        stall_prev;
    logic [11:0] prev_pl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] cur;
        logic [11:0] e;
        logic [9:0]  a;
        logic        c;
        if (reset_) begin
            cur = {out_sbid, out_sbresp, out_sbuser};
            if (stall_prev) begin
                chk("b_hold", {19'd0, out_sbvalid, cur}, {19'd0, 1'b1, prev_pl});
            end
            if (out_sbvalid && in_sbready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_spurious: got=%0h want=none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("b_payload", {20'd0, cur}, {20'd0, e});
                    nb++;
                end
            end
            stall_prev = out_sbvalid & ~in_sbready;
            prev_pl    = cur;
            if (in_sawvalid && out_sawready) model_aw.push_back({in_sawid, in_sawuser});
            if (in_swvalid && out_swready) begin
                if (in_swlast) begin
                    model_cmp.push_back(model_acc | in_swerr);
                    model_acc = 1'b0;
                end else begin
                    model_acc = model_acc | in_swerr;
                end
            end
            while (model_aw.size() > 0 && model_cmp.size() > 0) begin
                a = model_aw.pop_front();
                c = model_cmp.pop_front();
                exp_q.push_back({a[9:2], (c ? 2'b10 : 2'b00), a[1:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_sawvalid = 1'b0;
        in_sawid    = '0;
        in_sawuser  = '0;
        in_swvalid  = 1'b0;
        in_swlast   = 1'b0;
        in_swerr    = 1'b0;
    endtask

    // Asynchronous assert mid-cycle, check outputs at once, release away from the edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_ = 1'b0;
        #1;
        chk("rst_outputs", {out_sawready, out_swready, out_sbvalid, out_sbid, out_sbresp,
                            out_sbuser, out_pending}, 32'd0);
        model_aw.delete();
        model_cmp.delete();
        exp_q.delete();
        model_acc  = 1'b0;
        stall_prev = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        reset_ = 1'b1;
        #1;
        chk("rst_release_ready", {out_sawready, out_swready}, 2'b11);
    endtask

    task automatic drain(input string name);
        int n;
        idle_inputs();
        in_sbready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_sbvalid) && n < 200) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb0;
        int wsent;
        int highs;
        reset_     = 1'b1;
        in_sbready = 1'b1;
        model_acc  = 1'b0;
        stall_prev = 1'b0;
        prev_pl    = '0;
        idle_inputs();

        // Single write
        do_reset();
        in_sbready = 1'b1;
        step();
        in_sawvalid = 1'b1; in_sawid = 8'h12; in_sawuser = 2'b01;
        step();
        in_sawvalid = 1'b0;
        chk("t1_pending_1", out_pending, 1);
        in_swvalid = 1'b1; in_swlast = 1'b1; in_swerr = 1'b0;
        step();
        idle_inputs();
        chk("t1_no_b_yet", out_sbvalid, 0);
        step();
        chk("t1_b_valid", {out_sbvalid, out_sbid, out_sbuser, out_sbresp}, {1'b1, 8'h12, 2'b01, 2'b00});
        chk("t1_pending_0", out_pending, 0);
        step();
        chk("t1_b_one_cycle", out_sbvalid, 0);

        // WLAST before AW, with an error beat, then a clean burst
        do_reset();
        in_sbready = 1'b1;
        in_swvalid = 1'b1; in_swlast = 1'b0; in_swerr = 1'b0;
        step();
        in_swerr = 1'b1;
        step();
        in_swerr = 1'b0; in_swlast = 1'b1;
        step();
        in_swvalid = 1'b0; in_swlast = 1'b1; in_swerr = 1'b1;
        highs = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_sbvalid) highs++;
        end
        chk("t2_no_b_without_aw", highs, 0);
        idle_inputs();
        in_sawvalid = 1'b1; in_sawid = 8'h05; in_sawuser = 2'b10;
        step();
        in_sawvalid = 1'b0;
        chk("t2_no_b_same_cycle", out_sbvalid, 0);
        step();
        chk("t2_b_slverr", {out_sbvalid, out_sbid, out_sbresp}, {1'b1, 8'h05, 2'b10});
        in_sawvalid = 1'b1; in_sawid = 8'h06; in_sawuser = 2'b00;
        in_swvalid = 1'b1; in_swlast = 1'b1; in_swerr = 1'b0;
        step();
        idle_inputs();
        step();
        chk("t2_b_okay", {out_sbvalid, out_sbid, out_sbresp}, {1'b1, 8'h06, 2'b00});
        drain("t2_drain");

        // Full AW FIFO with B backpressure
        do_reset();
        in_sbready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            in_sawvalid = 1'b1; in_sawid = 8'(i); in_sawuser = 2'(i);
        end
        step();
        chk("t3_aw_full", out_sawready, 0);
        chk("t3_pending_8", out_pending, 8);
        in_sawid = 8'h99;
        step();
        step();
        in_sawvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_swvalid = 1'b1; in_swlast = 1'b1; in_swerr = (i == 3);
            step();
        end
        idle_inputs();
        repeat (3) step();
        chk("t3_first_b_held", {out_sbvalid, out_sbid}, {1'b1, 8'h00});
        chk("t3_pending_7", out_pending, 7);
        in_sbready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_b_order", {out_sbvalid, out_sbid}, {1'b1, 8'(i)});
            step();
        end
        chk("t3_b_done", out_sbvalid, 0);
        chk("t3_pending_0", out_pending, 0);
        drain("t3_drain");

        // Interleaved AWs and completions, B ready toggling every cycle
        do_reset();
        nb0 = nb;
        wsent = 0;
        for (int i = 0; i < 12; i++) begin
            in_sbready  = i[0];
            in_sawvalid = (i < 4);
            in_sawid    = 8'hA0 + 8'(i);
            in_sawuser  = 2'(i);
            in_swvalid  = ((i % 3) == 1) && (wsent < 4);
            in_swlast   = 1'b1;
            in_swerr    = (i == 4);
            if (in_swvalid) wsent++;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            in_sbready = i[0];
            step();
        end
        chk("t4_b_count", nb - nb0, 4);
        drain("t4_drain");

        // Reset while B is stalled and AWs are queued
        do_reset();
        in_sbready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_sawvalid = 1'b1; in_sawid = 8'h31 + 8'(i);
            step();
        end
        idle_inputs();
        in_swvalid = 1'b1; in_swlast = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();
        chk("t5_b_stalled", out_sbvalid, 1);
        chk("t5_pending_2", out_pending, 2);
        do_reset();
        chk("t5_pending_after", out_pending, 0);
        in_sbready = 1'b1;
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_sbvalid) highs++;
        end
        chk("t5_no_stale_b", highs, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_sawvalid = ($urandom_range(0, 2) == 0);
            in_sawid    = 8'($urandom);
            in_sawuser  = 2'($urandom);
            in_swvalid  = ($urandom_range(0, 1) == 1);
            in_swlast   = ($urandom_range(0, 2) == 0);
            in_swerr    = ($urandom_range(0, 3) == 0);
            in_sbready  = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand_drain");
        chk("rand_pending_left", out_pending, model_aw.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
